wb_pingpong_buffer: RTL and testbench

- Parametrised next-generation weight buffer: two ping-pong banks, each DEPTH x DATA_W.
- AXI BRAM controller port fills one bank while the PE array streams weights from the other.
- Internal read side is a burst engine. A single start command (base, length) streams consecutive words with a valid strobe.
- Bank ownership is tracked with full flags and a fill-done / release handshake.

---
 rtl/wb_pingpong_buffer.sv | 209 ++++++++++++++++++++
 tb/tb_wb_pingpong_buffer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_pingpong_buffer.sv
// wb_pingpong_buffer: two-bank ping-pong weight buffer.
// An AXI BRAM controller port fills one bank while a burst engine streams the other.
//
// Ports:
//   clk, rst (synchronous, active-low)
//   i_wb_bramctl_en/addr/we/wdata  : fill-side write port into bank fill_ptr
//   i_fill_done / o_fill_ready     : fill bank complete / fill bank writable
//   i_rd_start/base/len            : burst command (len 0 = no-op)
//   i_bank_release / o_rd_bank_vld : consumer hand-back / read bank valid
//   o_rd_busy, o_wdata, o_wdata_vld, o_rd_done : burst stream outputs
//
// Optional macro WB_BRAMCTL_RDBACK_EN adds o_wb_bramctl_rdata, a one-cycle
// read-back of the fill bank (en & ~we), allowed even when the bank is full.

module wb_pingpong_buffer #(
    parameter int DATA_W = 256,
    parameter int ADDR_W = 12,
    parameter int LEN_W  = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wb_bramctl_en,
    input  logic [ADDR_W-1:0] i_wb_bramctl_addr,
    input  logic              i_wb_bramctl_we,
    input  logic [DATA_W-1:0] i_wb_bramctl_wdata,
`ifdef WB_BRAMCTL_RDBACK_EN
    output logic [DATA_W-1:0] o_wb_bramctl_rdata,
`endif
    input  logic              i_fill_done,
    output logic              o_fill_ready,
    input  logic              i_rd_start,
    input  logic [ADDR_W-1:0] i_rd_base,
    input  logic [LEN_W-1:0]  i_rd_len,
    input  logic              i_bank_release,
    output logic              o_rd_bank_vld,
    output logic              o_rd_busy,
    output logic [DATA_W-1:0] o_wdata,
    output logic              o_wdata_vld,
    output logic              o_rd_done
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_DRAIN
    } state_t;

    state_t state_q, state_d;

    logic [1:0]        full_q, full_d;
    logic              fill_ptr_q, fill_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;

    logic              fill_ready;
    logic              wr_en;
    logic              start_ok;
    logic              rd_en;
    logic              last_beat;
    logic [ADDR_W-1:0] rd_addr;

    logic [DATA_W-1:0] mem0 [DEPTH];
    logic [DATA_W-1:0] mem1 [DEPTH];
    logic [DATA_W-1:0] rd_word;

    // Two-stage read path: RAM register, then output register.
    logic              s1_vld_q;
    logic              s1_last_q;
    logic [DATA_W-1:0] wdata_q;
    logic              wdata_vld_q;
    logic              rd_done_q;
    logic              busy_q;

    assign fill_ready = ~full_q[fill_ptr_q];
    assign wr_en      = i_wb_bramctl_en & i_wb_bramctl_we & fill_ready;
    assign start_ok   = i_rd_start & full_q[rd_ptr_q] & (i_rd_len != '0);
    // Address arithmetic wraps modulo DEPTH by truncation.
    assign rd_addr    = base_q + ADDR_W'(cnt_q);

    always_comb begin
        state_d    = state_q;
        full_d     = full_q;
        fill_ptr_d = fill_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        base_d     = base_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        rd_en      = 1'b0;
        last_beat  = 1'b0;

        // Evaluated on pre-edge flags: if both banks are full, this is
        // ignored even when a release happens in the same cycle.
        if (i_fill_done && fill_ready) begin
            full_d[fill_ptr_q] = 1'b1;
            fill_ptr_d         = ~fill_ptr_q;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    base_d  = i_rd_base;
                    len_d   = i_rd_len;
                    cnt_d   = '0;
                    state_d = S_BURST;
                end else if (i_bank_release && !i_rd_start
                             && full_q[rd_ptr_q]) begin
                    full_d[rd_ptr_q] = 1'b0;
                    rd_ptr_d         = ~rd_ptr_q;
                end
            end
            S_BURST: begin
                rd_en     = 1'b1;
                last_beat = (cnt_q == len_q - LEN_ONE);
                cnt_d     = cnt_q + LEN_ONE;
                if (last_beat) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            full_q     <= '0;
            fill_ptr_q <= 1'b0;
            rd_ptr_q   <= 1'b0;
            base_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            full_q     <= full_d;
            fill_ptr_q <= fill_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            base_q     <= base_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
        end
    end

    // RAM banks: not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (fill_ptr_q) begin
                mem1[i_wb_bramctl_addr] <= i_wb_bramctl_wdata;
            end else begin
                mem0[i_wb_bramctl_addr] <= i_wb_bramctl_wdata;
            end
        end
        if (rd_en) begin
            rd_word <= rd_ptr_q ? mem1[rd_addr] : mem0[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_vld_q    <= 1'b0;
            s1_last_q   <= 1'b0;
            wdata_q     <= '0;
            wdata_vld_q <= 1'b0;
            rd_done_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            s1_vld_q    <= rd_en;
            s1_last_q   <= last_beat;
            wdata_vld_q <= s1_vld_q;
            rd_done_q   <= s1_vld_q & s1_last_q;
            busy_q      <= (state_q != S_IDLE);
            if (s1_vld_q) begin
                wdata_q <= rd_word;
            end
        end
    end

`ifdef WB_BRAMCTL_RDBACK_EN
    logic [DATA_W-1:0] rdback_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rdback_q <= '0;
        end else if (i_wb_bramctl_en && !i_wb_bramctl_we) begin
            rdback_q <= fill_ptr_q ? mem1[i_wb_bramctl_addr]
                                   : mem0[i_wb_bramctl_addr];
        end
    end

    assign o_wb_bramctl_rdata = rdback_q;
`endif

    assign o_fill_ready  = fill_ready;
    assign o_rd_bank_vld = full_q[rd_ptr_q];
    assign o_rd_busy     = busy_q;
    assign o_wdata       = wdata_q;
    assign o_wdata_vld   = wdata_vld_q;
    assign o_rd_done     = rd_done_q;

endmodule

// File: tb/tb_wb_pingpong_buffer.sv
// tb_wb_pingpong_buffer: directed bench for wb_pingpong_buffer.
// Inputs change 1 ns after each rising edge; outputs are sampled there too.

module tb_wb_pingpong_buffer;

    localparam int DATA_W = 256;
    localparam int ADDR_W = 12;
    localparam int LEN_W  = 13;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_wb_bramctl_en;
    logic [ADDR_W-1:0] i_wb_bramctl_addr;
    logic              i_wb_bramctl_we;
    logic [DATA_W-1:0] i_wb_bramctl_wdata;
`ifdef WB_BRAMCTL_RDBACK_EN
    logic [DATA_W-1:0] o_wb_bramctl_rdata;
`endif
    logic              i_fill_done;
    logic              o_fill_ready;
    logic              i_rd_start;
    logic [ADDR_W-1:0] i_rd_base;
    logic [LEN_W-1:0]  i_rd_len;
    logic              i_bank_release;
    logic              o_rd_bank_vld;
    logic              o_rd_busy;
    logic [DATA_W-1:0] o_wdata;
    logic              o_wdata_vld;
    logic              o_rd_done;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] exp_d [8];

    wb_pingpong_buffer #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .LEN_W (LEN_W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .i_wb_bramctl_en   (i_wb_bramctl_en),
        .i_wb_bramctl_addr (i_wb_bramctl_addr),
        .i_wb_bramctl_we   (i_wb_bramctl_we),
        .i_wb_bramctl_wdata(i_wb_bramctl_wdata),
`ifdef WB_BRAMCTL_RDBACK_EN
        .o_wb_bramctl_rdata(o_wb_bramctl_rdata),
`endif
        .i_fill_done       (i_fill_done),
        .o_fill_ready      (o_fill_ready),
        .i_rd_start        (i_rd_start),
        .i_rd_base         (i_rd_base),
        .i_rd_len          (i_rd_len),
        .i_bank_release    (i_bank_release),
        .o_rd_bank_vld     (o_rd_bank_vld),
        .o_rd_busy         (o_rd_busy),
        .o_wdata           (o_wdata),
        .o_wdata_vld       (o_wdata_vld),
        .o_rd_done         (o_rd_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        i_wb_bramctl_en    = 1'b1;
        i_wb_bramctl_we    = 1'b1;
        i_wb_bramctl_addr  = a;
        i_wb_bramctl_wdata = d;
        step();
        i_wb_bramctl_en = 1'b0;
        i_wb_bramctl_we = 1'b0;
    endtask

    task automatic pulse_fill_done();
        i_fill_done = 1'b1;
        step();
        i_fill_done = 1'b0;
    endtask

    task automatic idle_start(input string tag, input logic [ADDR_W-1:0] b,
                              input int len);
        i_rd_start = 1'b1;
        i_rd_base  = b;
        i_rd_len   = LEN_W'(len);
        step();
        i_rd_start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            chk(tag, {o_rd_busy, o_wdata_vld, o_rd_done}, '0);
            step();
        end
    endtask

    // Start accepted at edge T; cycle c is sampled just after edge T+c.
    task automatic run_burst(input string tag, input logic [ADDR_W-1:0] b,
                             input int len, input bit rel_mid);
        i_rd_start = 1'b1;
        i_rd_base  = b;
        i_rd_len   = LEN_W'(len);
        step();
        i_rd_start = 1'b0;
        for (int c = 1; c <= len + 2; c++) begin
            if (rel_mid && c == 2) i_bank_release = 1'b1;
            step();
            i_bank_release = 1'b0;
            chk({tag, "_busy"}, o_rd_busy, (c <= len + 1));
            chk({tag, "_vld"}, o_wdata_vld, (c >= 2 && c <= len + 1));
            chk({tag, "_done"}, o_rd_done, (c == len + 1));
            if (c >= 2 && c <= len + 1) chk({tag, "_data"}, o_wdata, exp_d[c-2]);
        end
    endtask

    initial begin
        rst                = 1'b0;
        i_wb_bramctl_en    = 1'b0;
        i_wb_bramctl_addr  = '0;
        i_wb_bramctl_we    = 1'b0;
        i_wb_bramctl_wdata = '0;
        i_fill_done        = 1'b0;
        i_rd_start         = 1'b0;
        i_rd_base          = '0;
        i_rd_len           = '0;
        i_bank_release     = 1'b0;
        step();
        step();

        chk("rst_fill_ready", o_fill_ready, 1);
        chk("rst_rd_bank_vld", o_rd_bank_vld, 0);
        chk("rst_busy", o_rd_busy, 0);
        chk("rst_vld", o_wdata_vld, 0);
        chk("rst_done", o_rd_done, 0);
        chk("rst_wdata", o_wdata, 0);
        rst = 1'b1;
        step();

        idle_start("nofull_ign", 12'd0, 3);

        for (int i = 0; i < 5; i++) wr(ADDR_W'(i), DATA_W'(i + 1));
        pulse_fill_done();
        chk("fd0_rd_bank_vld", o_rd_bank_vld, 1);
        chk("fd0_fill_ready", o_fill_ready, 1);

        idle_start("len0_ign", 12'd0, 0);

        for (int i = 0; i < 5; i++) exp_d[i] = DATA_W'(i + 1);
        run_burst("b5", 12'd0, 5, 1'b0);
        step();
        chk("hold_wdata", o_wdata, 5);

        // Fill bank1 while releasing bank0 in the same cycle.
        wr(12'd0, 256'h11);
        wr(12'd1, 256'h22);
        i_fill_done    = 1'b1;
        i_bank_release = 1'b1;
        step();
        i_fill_done    = 1'b0;
        i_bank_release = 1'b0;
        chk("sim_fill_ready", o_fill_ready, 1);
        chk("sim_rd_bank_vld", o_rd_bank_vld, 1);

        wr(12'd4094, 256'hA);
        wr(12'd4095, 256'hB);
        wr(12'd0, 256'hC);
        wr(12'd1, 256'hD);
        pulse_fill_done();
        chk("both_full_ready", o_fill_ready, 0);
        wr(12'd0, 256'hFF);

        exp_d[0] = 256'h11;
        exp_d[1] = 256'h22;
        run_burst("b1", 12'd0, 2, 1'b0);

        // Release bank1 with a fill_done that must be ignored.
        i_fill_done    = 1'b1;
        i_bank_release = 1'b1;
        step();
        i_fill_done    = 1'b0;
        i_bank_release = 1'b0;
        chk("rel_fill_ready", o_fill_ready, 1);
        chk("rel_rd_bank_vld", o_rd_bank_vld, 1);

        exp_d[0] = 256'hA;
        exp_d[1] = 256'hB;
        exp_d[2] = 256'hC;
        exp_d[3] = 256'hD;
        run_burst("wrap", 12'd4094, 4, 1'b0);

        run_burst("relmid", 12'd4094, 4, 1'b1);
        step();
        chk("relmid_rd_bank_vld", o_rd_bank_vld, 1);

        // Reset while beat 2 of an 8-beat burst is on the output.
        i_rd_start = 1'b1;
        i_rd_base  = 12'd4094;
        i_rd_len   = 13'd8;
        step();
        i_rd_start = 1'b0;
        for (int c = 0; c < 4; c++) step();
        chk("mid_beat2_vld", o_wdata_vld, 1);
        chk("mid_beat2_data", o_wdata, 256'hC);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("mid_rst_vld", o_wdata_vld, 0);
        chk("mid_rst_busy", o_rd_busy, 0);
        chk("mid_rst_done", o_rd_done, 0);
        chk("mid_rst_fill_ready", o_fill_ready, 1);
        chk("mid_rst_rd_bank_vld", o_rd_bank_vld, 0);
        for (int c = 0; c < 6; c++) begin
            step();
            chk("post_rst_quiet", {o_rd_busy, o_wdata_vld, o_rd_done}, '0);
        end

`ifdef WB_BRAMCTL_RDBACK_EN
        chk("rdback_rst", o_wb_bramctl_rdata, 0);
        wr(12'd7, 256'h1234);
        i_wb_bramctl_en   = 1'b1;
        i_wb_bramctl_we   = 1'b0;
        i_wb_bramctl_addr = 12'd7;
        step();
        i_wb_bramctl_en = 1'b0;
        chk("rdback_data", o_wb_bramctl_rdata, 256'h1234);
        i_wb_bramctl_addr = 12'd0;
        step();
        chk("rdback_hold", o_wb_bramctl_rdata, 256'h1234);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
